// File: rtl/fp_pkg.sv
// Shared FP32 definitions for the accumulator: field layout, default adder
// latency, controller state encoding and the flush-to-zero test.
package fp_pkg;

   localparam int FP_W        = 32;
   localparam int FP_EXP_W    = 8;
   localparam int FP_MAN_W    = 23;
   localparam int FP_SIGN_BIT = 31;
   localparam int FP_EXP_MSB  = 30;
   localparam int FP_EXP_LSB  = 23;

   localparam int ADD_LAT_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } fp_state_e;

   // A value counts as zero when its exponent field is zero: denormals are
   // flushed and the sign bit is ignored.
   function automatic logic fp_is_zero(input logic [FP_W-1:0] v);
      return (v[FP_EXP_MSB:FP_EXP_LSB] == 8'd0);
   endfunction

endpackage

// File: rtl/fp_accumulator_if.sv
// Stream-in / sum-out handshake bundle of the FP32 accumulator.
interface fp_accumulator_if #(
   parameter int XLEN = 32
);
   logic            start;
   logic [15:0]     len;
   logic            in_valid;
   logic [XLEN-1:0] in_data;
   logic            in_ready;
   logic            sum_valid;
   logic [XLEN-1:0] sum_data;
   logic            sum_ready;
   logic            busy;

   modport master (
      output start, len, in_valid, in_data, sum_ready,
      input  in_ready, sum_valid, sum_data, busy
   );

   modport slave (
      input  start, len, in_valid, in_data, sum_ready,
      output in_ready, sum_valid, sum_data, busy
   );
endinterface

// File: rtl/FloatingAddition.sv
// FP32 adder: combinational round-to-nearest-even add followed by ADD_LAT
// register stages. Denormal inputs and results are flushed to zero.
module FloatingAddition
   import fp_pkg::*;
#(
   parameter int ADD_LAT = ADD_LAT_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            irst,
   input  logic [FP_W-1:0] A,
   input  logic [FP_W-1:0] B,
   output logic [FP_W-1:0] result
);

   function automatic logic [31:0] fp32_add(input logic [31:0] a, input logic [31:0] b);
      logic [31:0]       x;
      logic [31:0]       y;
      logic [7:0]        ex;
      logic [7:0]        ey;
      logic [7:0]        d;
      logic [26:0]       mx;
      logic [26:0]       my;
      logic [26:0]       shifted;
      logic              sticky;
      logic [27:0]       s;
      logic signed [9:0] e;
      logic [4:0]        lz;
      logic              round_up;
      logic [24:0]       mr;
      if (fp_is_zero(a)) begin
         return fp_is_zero(b) ? 32'h0000_0000 : b;
      end
      if (fp_is_zero(b)) begin
         return a;
      end
      // Larger magnitude goes to x so the difference path never goes negative.
      if (a[30:0] >= b[30:0]) begin
         x = a;
         y = b;
      end else begin
         x = b;
         y = a;
      end
      ex = x[30:23];
      ey = y[30:23];
      mx = {1'b1, x[22:0], 3'b000};
      my = {1'b1, y[22:0], 3'b000};
      d  = ex - ey;
      if (d > 8'd26) begin
         shifted = 27'd0;
         sticky  = 1'b1;
      end else begin
         shifted = my >> d;
         sticky  = |(my & ((27'd1 << d) - 27'd1));
      end
      shifted[0] = shifted[0] | sticky;
      e  = $signed({2'b00, ex});
      lz = 5'd0;
      if (x[31] == y[31]) begin
         s = {1'b0, mx} + {1'b0, shifted};
         if (s[27]) begin
            s = {1'b0, s[27:2], s[1] | s[0]};
            e = e + 10'sd1;
         end
      end else begin
         s = {1'b0, mx} - {1'b0, shifted};
         if (s == 28'd0) begin
            return 32'h0000_0000;
         end
         for (int i = 0; i < 27; i++) begin
            if (!s[26]) begin
               s  = s << 1;
               lz = lz + 5'd1;
            end
         end
         e = e - $signed({5'b00000, lz});
      end
      round_up = s[2] & (s[1] | s[0] | s[3]);
      mr = {1'b0, s[26:3]} + {24'd0, round_up};
      if (mr[24]) begin
         mr = mr >> 1;
         e  = e + 10'sd1;
      end
      if (e <= 10'sd0) begin
         return {x[31], 31'd0};
      end
      if (e >= 10'sd255) begin
         return {x[31], 8'hFF, 23'd0};
      end
      return {x[31], e[7:0], mr[22:0]};
   endfunction

   logic [FP_W-1:0] sum_s;
   logic [FP_W-1:0] pipe_q [ADD_LAT];

   // Unregistered sum of the current operands.
   always_comb begin
      sum_s = fp32_add(A, B);
   end

   // Delay line; either reset empties it so no stale sum survives.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ADD_LAT; i++) pipe_q[i] <= 32'h0000_0000;
      end else if (irst) begin
         for (int i = 0; i < ADD_LAT; i++) pipe_q[i] <= 32'h0000_0000;
      end else begin
         pipe_q[0] <= sum_s;
         for (int i = 1; i < ADD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign result = pipe_q[ADD_LAT-1];

endmodule

// File: rtl/fp_accumulator.sv
// Streaming FP32 reduction: sums len elements through a pipelined adder,
// loading the first (or any element onto a zero accumulator) directly and
// skipping zero elements.
module fp_accumulator
   import fp_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int ADD_LAT = ADD_LAT_DEF
) (
   input  logic              clk,
   input  logic              irst,
   fp_accumulator_if.slave   bus
);

   localparam logic [1:0] S_IDLE  = 2'(ST_IDLE);
   localparam logic [1:0] S_FETCH = 2'(ST_FETCH);
   localparam logic [1:0] S_WAIT  = 2'(ST_WAIT);
   localparam logic [1:0] S_DONE  = 2'(ST_DONE);

   logic [1:0]      state_q,     state_d;
   logic [XLEN-1:0] acc_q,       acc_d;
   logic [XLEN-1:0] op_a_q,      op_a_d;
   logic [XLEN-1:0] op_b_q,      op_b_d;
   logic [15:0]     remaining_q, remaining_d;
   logic [7:0]      wait_cnt_q,  wait_cnt_d;
   logic            first_q,     first_d;
   logic [XLEN-1:0] add_res_s;

   FloatingAddition #(
      .ADD_LAT(ADD_LAT)
   ) u_add (
      .clk   (clk),
      .rst_n (1'b1),
      .irst  (irst),
      .A     (op_a_q),
      .B     (op_b_q),
      .result(add_res_s)
   );

   // Next-state and datapath decisions of the reduction controller.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      remaining_d = remaining_q;
      wait_cnt_d  = wait_cnt_q;
      first_d     = first_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               acc_d = 32'h0000_0000;
               if (bus.len != 16'd0) begin
                  state_d     = S_FETCH;
                  remaining_d = bus.len;
                  first_d     = 1'b1;
               end else begin
                  state_d = S_DONE;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_FETCH: begin
            if (bus.in_valid) begin
               remaining_d = remaining_q - 16'd1;
               if (first_q || fp_is_zero(acc_q)) begin
                  acc_d   = bus.in_data;
                  first_d = 1'b0;
                  state_d = (remaining_q == 16'd1) ? S_DONE : S_FETCH;
               end else if (fp_is_zero(bus.in_data)) begin
                  state_d = (remaining_q == 16'd1) ? S_DONE : S_FETCH;
               end else begin
                  op_a_d     = acc_q;
                  op_b_d     = bus.in_data;
                  wait_cnt_d = 8'(ADD_LAT);
                  state_d    = S_WAIT;
               end
            end else begin
               state_d = S_FETCH;
            end
         end
         S_WAIT: begin
            // remaining was already decremented on accept, so zero here means
            // the element being captured was the last one.
            if (wait_cnt_q == 8'd0) begin
               acc_d   = add_res_s;
               state_d = (remaining_q == 16'd0) ? S_DONE : S_FETCH;
            end else begin
               wait_cnt_d = wait_cnt_q - 8'd1;
            end
         end
         S_DONE: begin
            if (bus.sum_ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Controller and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (irst) begin
         state_q     <= S_IDLE;
         acc_q       <= 32'h0000_0000;
         op_a_q      <= 32'h0000_0000;
         op_b_q      <= 32'h0000_0000;
         remaining_q <= 16'd0;
         wait_cnt_q  <= 8'd0;
         first_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         remaining_q <= remaining_d;
         wait_cnt_q  <= wait_cnt_d;
         first_q     <= first_d;
      end
   end

   assign bus.in_ready  = (state_q == S_FETCH);
   assign bus.sum_valid = (state_q == S_DONE);
   assign bus.sum_data  = (state_q == S_DONE) ? acc_q : 32'h0000_0000;
   assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_fp_accumulator.sv
// Directed bench for fp_accumulator: timing, cancellation, zero paths,
// backpressure, mid-flight reset and input gaps.
module tb_fp_accumulator;

   logic clk;
   logic irst;
   int   checks;
   int   failures;

   fp_accumulator_if #(.XLEN(32)) bus();

   fp_accumulator #(.XLEN(32), .ADD_LAT(4)) dut (
      .clk (clk),
      .irst(irst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wait_sum(input int max_cycles, input string tag);
      for (int i = 0; i < max_cycles && bus.sum_valid !== 1'b1; i++) step();
      check(tag, {31'd0, bus.sum_valid}, 32'd1);
   endtask

   task automatic handshake();
      bus.sum_ready = 1'b1;
      step();
      bus.sum_ready = 1'b0;
   endtask

   initial begin
      int gap;
      checks        = 0;
      failures      = 0;
      irst          = 1'b1;
      bus.start     = 1'b0;
      bus.len       = 16'd0;
      bus.in_valid  = 1'b0;
      bus.in_data   = 32'h0000_0000;
      bus.sum_ready = 1'b0;
      step();
      step();
      check("rst_busy",      {31'd0, bus.busy},      32'd0);
      check("rst_in_ready",  {31'd0, bus.in_ready},  32'd0);
      check("rst_sum_valid", {31'd0, bus.sum_valid}, 32'd0);
      check("rst_sum_data",  bus.sum_data,           32'h0000_0000);
      irst = 1'b0;
      step();

      // 1 + 2 + 3 with in_valid held high: accepts at s+1, s+2, s+8.
      bus.start    = 1'b1;
      bus.len      = 16'd3;
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h3F80_0000;
      step();                                  // edge s
      bus.start = 1'b0;
      check("t1_busy",      {31'd0, bus.busy},     32'd1);
      check("t1_ready_s",   {31'd0, bus.in_ready}, 32'd1);
      step();                                  // s+1 accept 1.0
      bus.in_data = 32'h4000_0000;
      check("t1_ready_s1",  {31'd0, bus.in_ready}, 32'd1);
      step();                                  // s+2 accept 2.0
      bus.in_data = 32'h4040_0000;
      check("t1_ready_s2",  {31'd0, bus.in_ready}, 32'd0);
      for (int i = 0; i < 4; i++) step();      // s+6
      check("t1_ready_s6",  {31'd0, bus.in_ready}, 32'd0);
      step();                                  // s+7 capture
      check("t1_ready_s7",  {31'd0, bus.in_ready}, 32'd1);
      step();                                  // s+8 accept 3.0
      check("t1_ready_s8",  {31'd0, bus.in_ready}, 32'd0);
      for (int i = 0; i < 4; i++) step();      // s+12
      check("t1_valid_s12", {31'd0, bus.sum_valid}, 32'd0);
      step();                                  // s+13
      check("t1_valid_s13", {31'd0, bus.sum_valid}, 32'd1);
      check("t1_sum",       bus.sum_data, 32'h40C0_0000);

      // Backpressure: sum held, start ignored, still busy.
      bus.len = 16'd5;
      for (int i = 0; i < 10; i++) begin
         bus.start = i[0];
         step();
         check("bp_valid", {31'd0, bus.sum_valid}, 32'd1);
         check("bp_data",  bus.sum_data, 32'h40C0_0000);
         check("bp_busy",  {31'd0, bus.busy}, 32'd1);
      end
      bus.start     = 1'b1;
      bus.len       = 16'd1;
      bus.sum_ready = 1'b1;
      step();                                  // handshake with start high
      bus.start     = 1'b0;
      bus.sum_ready = 1'b0;
      bus.in_valid  = 1'b0;
      check("hs_idle_busy",  {31'd0, bus.busy},      32'd0);
      check("hs_idle_valid", {31'd0, bus.sum_valid}, 32'd0);
      step();
      check("hs_no_start",   {31'd0, bus.busy},      32'd0);

      // 1 + (-1) cancels to +0.
      bus.start    = 1'b1;
      bus.len      = 16'd2;
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h3F80_0000;
      step();
      bus.start = 1'b0;
      step();
      bus.in_data = 32'hBF80_0000;
      step();
      bus.in_valid = 1'b0;
      wait_sum(20, "t2_timeout");
      check("t2_sum", bus.sum_data, 32'h0000_0000);
      handshake();

      // 0 then 0.5: both take the direct-load path.
      bus.start    = 1'b1;
      bus.len      = 16'd2;
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h0000_0000;
      step();                                  // edge s
      bus.start = 1'b0;
      step();                                  // s+1 accept 0
      bus.in_data = 32'h3F00_0000;
      step();                                  // s+2 accept 0.5
      bus.in_valid = 1'b0;
      check("t3_valid", {31'd0, bus.sum_valid}, 32'd1);
      check("t3_sum",   bus.sum_data, 32'h3F00_0000);
      handshake();

      // len == 0.
      bus.start = 1'b1;
      bus.len   = 16'd0;
      step();
      bus.start = 1'b0;
      check("t4_valid", {31'd0, bus.sum_valid}, 32'd1);
      check("t4_sum",   bus.sum_data, 32'h0000_0000);
      check("t4_ready", {31'd0, bus.in_ready}, 32'd0);
      handshake();

      // Reset while the second element is in the adder.
      bus.start    = 1'b1;
      bus.len      = 16'd3;
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h3F80_0000;
      step();
      bus.start = 1'b0;
      step();
      bus.in_data = 32'h4000_0000;
      step();
      bus.in_valid = 1'b0;
      step();
      step();
      irst = 1'b1;
      step();
      irst = 1'b0;
      check("t5_busy",  {31'd0, bus.busy},      32'd0);
      check("t5_ready", {31'd0, bus.in_ready},  32'd0);
      check("t5_valid", {31'd0, bus.sum_valid}, 32'd0);
      check("t5_data",  bus.sum_data,           32'h0000_0000);
      for (int i = 0; i < 8; i++) step();
      check("t5_still_idle", {31'd0, bus.busy}, 32'd0);
      bus.start    = 1'b1;
      bus.len      = 16'd1;
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h4040_0000;
      step();
      bus.start = 1'b0;
      step();
      bus.in_valid = 1'b0;
      wait_sum(5, "t5_timeout");
      check("t5_sum", bus.sum_data, 32'h4040_0000);
      handshake();

      // Four 1.0 elements with idle gaps between them.
      bus.start    = 1'b1;
      bus.len      = 16'd4;
      bus.in_valid = 1'b0;
      bus.in_data  = 32'h3F80_0000;
      step();
      bus.start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         gap = int'($urandom_range(0, 3));
         for (int g = 0; g < gap; g++) step();
         bus.in_valid = 1'b1;
         for (int w = 0; w < 20 && bus.in_ready !== 1'b1; w++) step();
         check("t6_ready", {31'd0, bus.in_ready}, 32'd1);
         step();
         bus.in_valid = 1'b0;
      end
      wait_sum(30, "t6_timeout");
      check("t6_sum", bus.sum_data, 32'h4080_0000);
      handshake();
      check("t6_idle", {31'd0, bus.busy}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fp_accumulator.md
FP_ACCUMULATOR -- requirements
Module: fp_accumulator

Interface
REQ-001 Parameter XLEN, default 32, operand width; only 32 (FP32) is supported.
REQ-002 Parameter ADD_LAT, default 4, number of register stages in the adder, from operand sampled to result registered.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 irst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle request to begin a reduction; sampled only in IDLE.
REQ-006 len  input  16  element count, latched on accepted start.
REQ-007 in_valid  input  1  upstream element valid.
REQ-008 in_data  input  XLEN  FP32 element.
REQ-009 in_ready  output  1  element accepted on edge where in_valid&in_ready.
REQ-010 sum_valid  output  1  final sum available.
REQ-011 sum_data  output  XLEN  FP32 sum.
REQ-012 sum_ready  input  1  downstream accepts sum on edge where sum_valid&sum_ready.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 States: IDLE, FETCH, WAIT, DONE; all outputs are decoded from registered state and registers only.
REQ-015 IDLE: start=1 with len!=0 -> FETCH, remaining<=len, acc<=0, first<=1; start=1 with len==0 -> DONE with acc=0; start in other states ignored.
REQ-016 FETCH: in_ready=1; all other states in_ready=0.
REQ-017 Zero test: element or acc is zero when exponent field==0 (denormals flushed to zero, sign ignored).
REQ-018 Accepted element with first=1, or acc zero: acc<=in_data, first<=0, no adder trip.
REQ-019 Accepted zero element (first=0, acc non-zero): acc unchanged, no adder trip.
REQ-020 Other accepted elements: operand registers op_a<=acc, op_b<=in_data, wait_cnt<=ADD_LAT, state->WAIT.
REQ-021 WAIT: wait_cnt decrements each cycle; on the edge where wait_cnt==0, acc<=adder result; capture edge is ADD_LAT+1 edges after the accept edge.
REQ-022 remaining decrements on every accept; when the accept (no-trip case) or capture (trip case) completes the element with remaining==1 -> DONE, else -> FETCH.
REQ-023 DONE: sum_valid=1, sum_data=acc held stable until sum_ready; on handshake -> IDLE, the same edge does not accept start.
REQ-024 Throughput: direct-load/zero elements 1 cycle each; added elements ADD_LAT+2 cycles each, including the accept cycle.
REQ-025 Inf/NaN receive no special handling; they pass through the adder as encoded.
REQ-026 Adder operands are op_a/op_b registers, held constant outside accept edges.

Reset
REQ-027 irst=1: state=IDLE, acc=0, op_a=op_b=0, remaining=0, wait_cnt=0, first=0; in_ready=0, sum_valid=0, sum_data=0, busy=0 from the next cycle.
REQ-028 irst mid-reduction discards the in-flight adder result; the adder sub-module receives the same irst, so no stale result is captured afterward.
REQ-029 irst takes priority over start and all handshakes on the same edge.

Structure
REQ-030 Shared package fp_pkg holds: FP32 field widths/positions, ADD_LAT default, the state enum, and the zero-test function.
REQ-031 One sub-module: FloatingAddition, A=op_a, B=op_b, result feeds the capture, irst=irst, rst_n tied to 1.

Verification
REQ-032 len=3, in_valid held high, elements 3F800000, 40000000, 40400000, start accepted on edge s -> accepts on edges s+1, s+2, s+8; sum_valid rises after edge s+13, sum_data=40C00000.
REQ-033 len=2, elements 3F800000, BF800000 -> sum_data=00000000; then a further reduction len=2, elements 00000000, 3F000000 -> sum_data=3F000000 with zero direct-load path, sum_valid within 3 cycles of the start edge.
REQ-034 len=0 start -> sum_valid next cycle, sum_data=00000000, in_ready never high.
REQ-035 Backpressure: sum_ready low 10 cycles in DONE -> sum_data/sum_valid stable, start pulses ignored, busy=1; IDLE on the cycle after the handshake.
REQ-036 irst asserted during WAIT (element 2 of 3) -> IDLE next cycle, all outputs zero; a new len=1 reduction with 40400000 returns 40400000, uncorrupted.
REQ-037 in_valid gaps: random idle cycles between elements 3F800000 x4 -> sum_data=40800000, no element lost or duplicated.
